// File: rtl/instr_fetch.sv
// Instruction fetch for the single-cycle LEGv8 CPU: PC register, field slicing,
// NZCV flag register and next-PC resolution. Define FETCH_BL_EN to enable BL (br_type 5).
module instr_fetch #(
    parameter int unsigned      PC_W     = 64,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [4:0]      Rd,
    output logic [4:0]      Rn,
    output logic [4:0]      Rm,
    output logic [8:0]      Daddr9,
    output logic [11:0]     Imm12,
    output logic [1:0]      Shamt,
    output logic [15:0]     Imm16,
    input  logic [2:0]      br_type,
    input  logic            cbz_zero,
    input  logic [PC_W-1:0] br_reg,
    input  logic            set_flags,
    input  logic [3:0]      flags_in,
    output logic [3:0]      flags,
    output logic            link_wr,
    output logic [PC_W-1:0] link_addr
);

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned IMM26_W     = 26;
    localparam int unsigned IMM19_W     = 19;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_CBZ   = 3'd2,
        BR_BCOND = 3'd3,
        BR_REG   = 3'd4,
        BR_BL    = 3'd5
    } br_type_e;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      flags_q, flags_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br26_off;
    logic [PC_W-1:0] br19_off;
    logic            cond_taken;

    // BR target alignment discards the two low register bits.
    logic [1:0] unused_br_reg_lsb;
    assign unused_br_reg_lsb = br_reg[1:0];

    // B.cond evaluation against the registered {N,Z,C,V}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        res = 1'b1;
        case (cond)
            4'h0:    res = z;
            4'h1:    res = !z;
            4'h2:    res = c;
            4'h3:    res = !c;
            4'h4:    res = n;
            4'h5:    res = !n;
            4'h6:    res = v;
            4'h7:    res = !v;
            4'h8:    res = c && !z;
            4'h9:    res = !(c && !z);
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = !z && (n == v);
            4'hD:    res = !(!z && (n == v));
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Field buses are zero-latency slices of the fetched word.
    assign imem_addr = pc_q;
    assign instr     = imem_rdata;
    assign Rd        = imem_rdata[4:0];
    assign Rn        = imem_rdata[9:5];
    assign Rm        = imem_rdata[20:16];
    assign Daddr9    = imem_rdata[20:12];
    assign Imm12     = imem_rdata[21:10];
    assign Shamt     = imem_rdata[22:21];
    assign Imm16     = imem_rdata[20:5];
    assign flags     = flags_q;

    // Word offsets, sign-extended and scaled to bytes; sums wrap modulo 2^PC_W.
    assign br26_off = {{(PC_W-IMM26_W-2){imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
    assign br19_off = {{(PC_W-IMM19_W-2){imem_rdata[23]}}, imem_rdata[23:5], 2'b00};
    assign pc_plus4 = pc_q + PC_W'(INSTR_BYTES);
    assign cond_taken = cond_met(imem_rdata[3:0], flags_q);

    // Next-PC selection.
    always_comb begin
        pc_d = pc_plus4;
        if (stall) begin
            pc_d = pc_q;
        end else begin
            case (br_type)
                BR_B:     pc_d = pc_q + br26_off;
                BR_CBZ:   pc_d = cbz_zero   ? (pc_q + br19_off) : pc_plus4;
                BR_BCOND: pc_d = cond_taken ? (pc_q + br19_off) : pc_plus4;
                BR_REG:   pc_d = {br_reg[PC_W-1:2], 2'b00};
`ifdef FETCH_BL_EN
                BR_BL:    pc_d = pc_q + br26_off;
`endif
                default:  pc_d = pc_plus4;
            endcase
        end
    end

    // Flags update only on retiring flag-setting instructions.
    always_comb begin
        flags_d = flags_q;
        if (!stall && set_flags) begin
            flags_d = flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            flags_q <= 4'b0000;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

`ifdef FETCH_BL_EN
    // Link strobe is combinational so the datapath writes X30 in the BL cycle.
    assign link_wr   = (br_type == BR_BL) && !stall && !reset;
    assign link_addr = pc_plus4;
`else
    assign link_wr   = 1'b0;
    assign link_addr = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expectations adapt to FETCH_BL_EN.
module tb_instr_fetch;

    localparam int unsigned PC_W = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic [4:0]      Rd, Rn, Rm;
    logic [8:0]      Daddr9;
    logic [11:0]     Imm12;
    logic [1:0]      Shamt;
    logic [15:0]     Imm16;
    logic [2:0]      br_type;
    logic            cbz_zero;
    logic [PC_W-1:0] br_reg;
    logic            set_flags;
    logic [3:0]      flags_in;
    logic [3:0]      flags;
    logic            link_wr;
    logic [PC_W-1:0] link_addr;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
        .Rd(Rd), .Rn(Rn), .Rm(Rm), .Daddr9(Daddr9), .Imm12(Imm12),
        .Shamt(Shamt), .Imm16(Imm16),
        .br_type(br_type), .cbz_zero(cbz_zero), .br_reg(br_reg),
        .set_flags(set_flags), .flags_in(flags_in), .flags(flags),
        .link_wr(link_wr), .link_addr(link_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set up the next instruction's inputs, then let combinational outputs settle.
    task automatic drive(input logic [31:0] w, input logic [2:0] bt);
        imem_rdata = w;
        br_type    = bt;
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_rdata = 32'h12345678; br_type = 3'd0;
        cbz_zero = 1'b0; br_reg = '0; set_flags = 1'b0; flags_in = 4'b0000;
        tick();
        check("rst_pc", imem_addr, 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_link_wr", 64'(link_wr), 64'd0);
        check("f_instr", 64'(instr), 64'h12345678);
        check("f_rd", 64'(Rd), 64'd24);
        check("f_rn", 64'(Rn), 64'd19);
        check("f_rm", 64'(Rm), 64'd20);
        check("f_daddr9", 64'(Daddr9), 64'h145);
        check("f_imm12", 64'(Imm12), 64'hD15);
        check("f_shamt", 64'(Shamt), 64'd1);
        check("f_imm16", 64'(Imm16), 64'hA2B3);

        reset = 1'b0;
        drive(32'h8B020020, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", imem_addr, 64'(4 * i));
        end

        // Load flags, then reset must clear PC and flags despite branch/set_flags.
        set_flags = 1'b1; flags_in = 4'b1010;
        tick();
        check("flags_load", 64'(flags), 64'hA);
        check("pc_16", imem_addr, 64'd16);
        reset = 1'b1; flags_in = 4'b1111;
        drive(32'h14000003, 3'd1);
        tick();
        check("rst2_pc", imem_addr, 64'd0);
        check("rst2_flags", 64'(flags), 64'd0);
        reset = 1'b0; set_flags = 1'b0;

        // B backward and forward.
        drive(32'h8B020020, 3'd0);
        tick(); tick();
        check("pc_8", imem_addr, 64'd8);
        drive(32'h17FFFFFE, 3'd1);
        tick();
        check("b_back", imem_addr, 64'd0);
        drive(32'h14000003, 3'd1);
        tick();
        check("b_fwd", imem_addr, 64'd12);

        // Z flag set, then conditional branches.
        set_flags = 1'b1; flags_in = 4'b0100;
        drive(32'hAB020020, 3'd0);
        tick();
        set_flags = 1'b0;
        check("flags_z", 64'(flags), 64'h4);
        check("pc_16b", imem_addr, 64'd16);
        drive(32'h54000080, 3'd3);
        tick();
        check("bcond_eq", imem_addr, 64'd32);
        drive(32'h54000081, 3'd3);
        tick();
        check("bcond_ne", imem_addr, 64'd36);
        drive(32'h5400008C, 3'd3);
        tick();
        check("bcond_gt", imem_addr, 64'd40);

        // CBZ with imm19 = -1, then BR alignment.
        cbz_zero = 1'b1;
        drive(32'hB4FFFFE0, 3'd2);
        tick();
        check("cbz_taken", imem_addr, 64'd36);
        cbz_zero = 1'b0;
        tick();
        check("cbz_not", imem_addr, 64'd40);
        br_reg = 64'h103;
        drive(32'hD61F0000, 3'd4);
        tick();
        check("br_align", imem_addr, 64'h100);

        // Stall holds PC and flags and blocks the branch.
        stall = 1'b1; set_flags = 1'b1; flags_in = 4'b1111;
        drive(32'h14000003, 3'd1);
        check("stall_link", 64'(link_wr), 64'd0);
        tick(); tick();
        check("stall_pc", imem_addr, 64'h100);
        check("stall_flags", 64'(flags), 64'h4);
        check("stall_rm", 64'(Rm), 64'd0);
        stall = 1'b0;
        tick();
        check("unstall_pc", imem_addr, 64'h10C);
        check("unstall_flags", 64'(flags), 64'hF);
        set_flags = 1'b0;
        drive(32'h5400004B, 3'd3);
        tick();
        check("bcond_lt", imem_addr, 64'h110);
        drive(32'h5400004A, 3'd3);
        tick();
        check("bcond_ge", imem_addr, 64'h118);
        drive(32'h8B020020, 3'd6);
        tick();
        check("brtype6", imem_addr, 64'h11C);

        // Wrap-around at the top of the address space.
        br_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(32'hD61F0000, 3'd4);
        tick();
        check("pc_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        drive(32'h8B020020, 3'd0);
        tick();
        check("pc_wrap", imem_addr, 64'd0);

        // BL behaviour depends on the build.
        drive(32'h14000005, 3'd1);
        tick();
        check("pc_20", imem_addr, 64'd20);
        drive(32'h94000008, 3'd5);
`ifdef FETCH_BL_EN
        check("bl_link_wr", 64'(link_wr), 64'd1);
        check("bl_link_addr", link_addr, 64'd24);
        tick();
        check("bl_pc", imem_addr, 64'd52);
`else
        check("bl_link_wr", 64'(link_wr), 64'd0);
        check("bl_link_addr", link_addr, 64'd0);
        tick();
        check("bl_pc", imem_addr, 64'd24);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
